branch_history_table: RTL and testbench
=======================================

// Module: branch_history_table
// PURPOSE
//  Per-branch local history table feeding the PHT set-of-counters stage.
//  - Holds one HIST_W-bit outcome shift register per PC index (PC[9:2]).
//  - Lookup: supplies BHR for the fetch PC.
//  - Resolve: supplies the pre-shift BHR plus a delayed update strobe so the
//    PHT trains on the same history that produced the prediction, then shifts
//    in the outcome.
// PARAMETERS
//  HIST_W   8   history bits per entry; equals PHT BHR width
//  IDX_W    8   index bits taken from PC[9:2]; table depth = 2**IDX_W
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       asynchronous, active-low reset
//  flush            in   1       sync request to re-clear the whole table
//  currentPC_lower  in   IDX_W   fetch-side index (PC[9:2])
//  BHR_predict      out  HIST_W  registered history for currentPC_lower
//  update           in   1       resolved-branch strobe, 1 cycle per branch
//  branchPC_lower   in   IDX_W   resolved-branch index
//  taken            in   1       resolved outcome
//  ready            out  1       1 = table usable; 0 during clear sweep
//  update_out       out  1       to PHT update, 1 cycle after accepted update
//  BHR_update       out  HIST_W  pre-shift history of the resolved branch
//  branchPC_out     out  IDX_W   index echoed with update_out
//  taken_out        out  1       outcome echoed with update_out
// BEHAVIOUR
//  - Reset (rst=0, async): FSM->INIT, clr_cnt=0, ready=0, BHR_predict=0,
//    update_out=0, BHR_update=0, branchPC_out=0, taken_out=0. Table array
//    has no reset; INIT clears it.
//  - FSM INIT: each cycle table[clr_cnt]<=0, clr_cnt++. At clr_cnt==2**IDX_W-1
//    write the last entry, go RUN next cycle. INIT lasts exactly 2**IDX_W
//    cycles; ready=1 from the first RUN cycle.
//  - FSM RUN: flush=1 -> INIT, clr_cnt=0. Same-cycle update is dropped.
//  - Update accepted only when update && ready && !flush. On that edge:
//    table[b] <= {table[b][HIST_W-2:0], taken}; update_out<=1;
//    BHR_update<=table[b] (old value); branchPC_out<=b; taken_out<=taken.
//  - update_out is 0 every cycle without an accepted update. Echo outputs hold
//    their last value.
//  - update while ready=0: ignored. No queueing; the caller holds or drops.
//  - Back-to-back updates to the same index: each reads the value written by
//    the previous edge. Two shifts occur; the second BHR_update shows the
//    first shift.
//  - Lookup: BHR_predict <= table[currentPC_lower] every RUN cycle (1-cycle
//    latency). Write-first: if the same edge accepts an update to that index,
//    BHR_predict takes the post-shift value. In INIT, BHR_predict <= 0.
//  - History is a plain shift: newest outcome in bit 0, oldest bit drops.
//    No saturation, no arithmetic.
// STRUCTURE
//  - Shared package: HIST_W/IDX_W defaults, FSM state encoding
//    (BHT_INIT, BHT_RUN). The PHT uses the same width constants.
//  - Single module. The array plus sweep counter stays inline; no sub-module.
// TESTING
//  1. Release rst, hold update=0: ready=0 for 256 cycles, then 1;
//     BHR_predict=0 for every index.
//  2. ready=1, update b=0x12 taken=1,1,0 on 3 consecutive cycles:
//     BHR_update=00,01,03 with update_out high for 3 cycles;
//     then lookup 0x12 gives 0x06.
//  3. Same edge: update b=0x40 taken=1 and currentPC_lower=0x40, entry 0x05:
//     BHR_predict=0x0B next cycle (write-first).
//  4. After 9 taken updates to 0x7F: entry=0xFF; one not-taken gives 0xFE
//     (oldest bit shifted out).
//  5. flush with update on the same cycle: update_out=0, ready=0 for 256
//     cycles, all entries 0 after.
//  6. Assert rst mid-INIT and mid-update: outputs go 0 immediately; the sweep
//     restarts at index 0.

Source files
------------

// File: rtl/branch_history_table_pkg.sv
// Shared constants and FSM encoding for the branch history table and its PHT consumer.
//   BHT_HIST_W : history bits per entry (also the PHT BHR width)
//   BHT_IDX_W  : index bits taken from PC[9:2]
//   BHT_DEPTH  : number of table entries
package branch_history_table_pkg;

    localparam int unsigned BHT_HIST_W = 8;
    localparam int unsigned BHT_IDX_W  = 8;
    localparam int unsigned BHT_DEPTH  = 2 ** BHT_IDX_W;

    typedef enum logic {
        BHT_INIT = 1'b0,
        BHT_RUN  = 1'b1
    } bht_state_e;

endpackage

// File: rtl/branch_history_table_if.sv
// Lookup/resolve bundle between the fetch/resolve logic (master) and the BHT (slave).
//   flush, currentPC_lower, update, branchPC_lower, taken : master -> slave
//   BHR_predict, ready, update_out, BHR_update,
//   branchPC_out, taken_out                               : slave -> master
interface branch_history_table_if
    import branch_history_table_pkg::*;
#(
    parameter int unsigned HIST_W = BHT_HIST_W,
    parameter int unsigned IDX_W  = BHT_IDX_W
);

    logic              flush;
    logic [IDX_W-1:0]  currentPC_lower;
    logic [HIST_W-1:0] BHR_predict;
    logic              update;
    logic [IDX_W-1:0]  branchPC_lower;
    logic              taken;
    logic              ready;
    logic              update_out;
    logic [HIST_W-1:0] BHR_update;
    logic [IDX_W-1:0]  branchPC_out;
    logic              taken_out;

    modport master (
        output flush, currentPC_lower, update, branchPC_lower, taken,
        input  BHR_predict, ready, update_out, BHR_update, branchPC_out, taken_out
    );

    modport slave (
        input  flush, currentPC_lower, update, branchPC_lower, taken,
        output BHR_predict, ready, update_out, BHR_update, branchPC_out, taken_out
    );

endinterface

// File: rtl/branch_history_table.sv
// Per-branch local history table: one shift register of outcomes per PC index.
// Lookup returns the registered history for the fetch index (write-first against
// a same-edge update). Resolve echoes the pre-shift history with a one-cycle
// strobe so the PHT trains on the history that produced the prediction.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   bus   : slave side of branch_history_table_if (lookup, resolve, echo, ready)
module branch_history_table
    import branch_history_table_pkg::*;
#(
    parameter int unsigned HIST_W = BHT_HIST_W,
    parameter int unsigned IDX_W  = BHT_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_history_table_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    // History storage; cleared by the INIT sweep rather than by reset.
    logic [HIST_W-1:0] table_mem [DEPTH];

    bht_state_e        state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;
    logic [HIST_W-1:0] bhr_predict_q, bhr_predict_d;
    logic              update_out_q, update_out_d;
    logic [HIST_W-1:0] bhr_update_q, bhr_update_d;
    logic [IDX_W-1:0]  branch_pc_out_q, branch_pc_out_d;
    logic              taken_out_q, taken_out_d;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [HIST_W-1:0] wr_data;

    logic [HIST_W-1:0] hist_old;
    logic [HIST_W-1:0] hist_new;
    logic [HIST_W-1:0] hist_look;
    logic              accept;

    // Table read ports and the shifted history of the resolving branch.
    always_comb begin
        hist_old  = table_mem[bus.branchPC_lower];
        hist_new  = {hist_old[HIST_W-2:0], bus.taken};
        hist_look = table_mem[bus.currentPC_lower];
        accept    = bus.update && ready_q && !bus.flush;
    end

    // Next-state, table write and registered-output logic.
    always_comb begin
        state_d         = state_q;
        clr_cnt_d       = clr_cnt_q;
        bhr_predict_d   = bhr_predict_q;
        update_out_d    = 1'b0;
        bhr_update_d    = bhr_update_q;
        branch_pc_out_d = branch_pc_out_q;
        taken_out_d     = taken_out_q;
        wr_en           = 1'b0;
        wr_idx          = clr_cnt_q;
        wr_data         = '0;

        unique case (state_q)
            BHT_INIT: begin
                wr_en         = 1'b1;
                wr_idx        = clr_cnt_q;
                wr_data       = '0;
                clr_cnt_d     = clr_cnt_q + IDX_W'(1);
                bhr_predict_d = '0;
                if (clr_cnt_q == {IDX_W{1'b1}}) begin
                    state_d = BHT_RUN;
                end
            end
            BHT_RUN: begin
                if (bus.flush) begin
                    state_d   = BHT_INIT;
                    clr_cnt_d = '0;
                end
                if (accept) begin
                    wr_en           = 1'b1;
                    wr_idx          = bus.branchPC_lower;
                    wr_data         = hist_new;
                    update_out_d    = 1'b1;
                    bhr_update_d    = hist_old;
                    branch_pc_out_d = bus.branchPC_lower;
                    taken_out_d     = bus.taken;
                end
                // Write-first: a same-edge update to the looked-up index wins.
                if (accept && (bus.branchPC_lower == bus.currentPC_lower)) begin
                    bhr_predict_d = hist_new;
                end else begin
                    bhr_predict_d = hist_look;
                end
            end
            default: begin
                state_d = BHT_INIT;
            end
        endcase

        ready_d = (state_d == BHT_RUN);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= BHT_INIT;
            clr_cnt_q       <= '0;
            ready_q         <= 1'b0;
            bhr_predict_q   <= '0;
            update_out_q    <= 1'b0;
            bhr_update_q    <= '0;
            branch_pc_out_q <= '0;
            taken_out_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            ready_q         <= ready_d;
            bhr_predict_q   <= bhr_predict_d;
            update_out_q    <= update_out_d;
            bhr_update_q    <= bhr_update_d;
            branch_pc_out_q <= branch_pc_out_d;
            taken_out_q     <= taken_out_d;
        end
    end

    // Table write port (single writer: sweep or accepted update).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[wr_idx] <= wr_data;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.BHR_predict  = bhr_predict_q;
    assign bus.update_out   = update_out_q;
    assign bus.BHR_update   = bhr_update_q;
    assign bus.branchPC_out = branch_pc_out_q;
    assign bus.taken_out    = taken_out_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table: vector table for lookup/resolve
// behaviour plus hand-written flush and reset sequences.
module tb_branch_history_table;

    logic clk;
    logic rst;

    branch_history_table_if bus_if ();

    branch_history_table dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    typedef struct {
        logic       upd;
        logic [7:0] b;
        logic       tk;
        logic [7:0] cur;
        logic       e_uo;
        logic [7:0] e_bu;
        logic [7:0] e_pc;
        logic       e_tk;
        logic [7:0] e_pred;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic upd, logic [7:0] b, logic tk, logic [7:0] cur,
                                logic e_uo, logic [7:0] e_bu, logic [7:0] e_pc,
                                logic e_tk, logic [7:0] e_pred);
        vec_t v;
        v.upd = upd; v.b = b; v.tk = tk; v.cur = cur;
        v.e_uo = e_uo; v.e_bu = e_bu; v.e_pc = e_pc; v.e_tk = e_tk; v.e_pred = e_pred;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises; an expired budget shows up as a wrong count.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (bus_if.ready !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk(name, 32'(n), 32'd256);
    endtask

    task automatic scan_zero(input string name);
        bus_if.update = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus_if.currentPC_lower = 8'(i);
            step();
            chk(name, 32'(bus_if.BHR_predict), 32'h0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  32'(bus_if.ready),        32'h0);
        chk({tag, "_uo"},     32'(bus_if.update_out),   32'h0);
        chk({tag, "_bu"},     32'(bus_if.BHR_update),   32'h0);
        chk({tag, "_pc"},     32'(bus_if.branchPC_out), 32'h0);
        chk({tag, "_tk"},     32'(bus_if.taken_out),    32'h0);
        chk({tag, "_pred"},   32'(bus_if.BHR_predict),  32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus_if.flush           = 1'b0;
        bus_if.update          = 1'b0;
        bus_if.branchPC_lower  = '0;
        bus_if.taken           = 1'b0;
        bus_if.currentPC_lower = '0;

        // Lookup/resolve vectors: apply before an edge, check after it.
        vecs.push_back(mk(1, 8'h12, 1, 8'h00, 1, 8'h00, 8'h12, 1, 8'h00));
        vecs.push_back(mk(1, 8'h12, 1, 8'h00, 1, 8'h01, 8'h12, 1, 8'h00));
        vecs.push_back(mk(1, 8'h12, 0, 8'h00, 1, 8'h03, 8'h12, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h12, 0, 8'h03, 8'h12, 0, 8'h06));
        vecs.push_back(mk(1, 8'h40, 1, 8'h00, 1, 8'h00, 8'h40, 1, 8'h00));
        vecs.push_back(mk(1, 8'h40, 0, 8'h00, 1, 8'h01, 8'h40, 0, 8'h00));
        vecs.push_back(mk(1, 8'h40, 1, 8'h00, 1, 8'h02, 8'h40, 1, 8'h00));
        vecs.push_back(mk(1, 8'h40, 1, 8'h40, 1, 8'h05, 8'h40, 1, 8'h0B));
        vecs.push_back(mk(0, 8'h00, 0, 8'h40, 0, 8'h05, 8'h40, 1, 8'h0B));
        for (int k = 0; k < 9; k++) begin
            vecs.push_back(mk(1, 8'h7F, 1, 8'h00, 1, 8'((1 << k) - 1), 8'h7F, 1, 8'h00));
        end
        vecs.push_back(mk(1, 8'h7F, 0, 8'h00, 1, 8'hFF, 8'h7F, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h7F, 0, 8'hFF, 8'h7F, 0, 8'hFE));
        vecs.push_back(mk(0, 8'h00, 0, 8'h12, 0, 8'hFF, 8'h7F, 0, 8'h06));

        // Reset state.
        #2;
        chk_all_zero("reset");

        // Release reset: 256-cycle sweep, then every entry reads zero.
        step();
        rst = 1'b1;
        wait_ready("init_latency");
        scan_zero("init_entry");

        // Table-driven lookup/resolve checks.
        for (int i = 0; i < vecs.size(); i++) begin
            bus_if.update          = vecs[i].upd;
            bus_if.branchPC_lower  = vecs[i].b;
            bus_if.taken           = vecs[i].tk;
            bus_if.currentPC_lower = vecs[i].cur;
            step();
            chk($sformatf("v%0d_uo", i),   32'(bus_if.update_out),   32'(vecs[i].e_uo));
            chk($sformatf("v%0d_bu", i),   32'(bus_if.BHR_update),   32'(vecs[i].e_bu));
            chk($sformatf("v%0d_pc", i),   32'(bus_if.branchPC_out), 32'(vecs[i].e_pc));
            chk($sformatf("v%0d_tk", i),   32'(bus_if.taken_out),    32'(vecs[i].e_tk));
            chk($sformatf("v%0d_pred", i), 32'(bus_if.BHR_predict),  32'(vecs[i].e_pred));
        end

        // Flush with a same-cycle update: update dropped, echoes held, full resweep.
        bus_if.flush          = 1'b1;
        bus_if.update         = 1'b1;
        bus_if.branchPC_lower = 8'h12;
        bus_if.taken          = 1'b1;
        step();
        bus_if.flush  = 1'b0;
        bus_if.update = 1'b0;
        chk("flush_uo",    32'(bus_if.update_out),   32'h0);
        chk("flush_ready", 32'(bus_if.ready),        32'h0);
        chk("flush_bu",    32'(bus_if.BHR_update),   32'hFF);
        chk("flush_pc",    32'(bus_if.branchPC_out), 32'h7F);
        chk("flush_tk",    32'(bus_if.taken_out),    32'h0);
        wait_ready("flush_latency");
        scan_zero("flush_entry");

        // Reset mid-update: outputs clear asynchronously, sweep restarts.
        bus_if.update          = 1'b1;
        bus_if.branchPC_lower  = 8'h33;
        bus_if.taken           = 1'b1;
        bus_if.currentPC_lower = 8'h33;
        step();
        chk("pre_rst_bu1",   32'(bus_if.BHR_update),  32'h00);
        chk("pre_rst_pred1", 32'(bus_if.BHR_predict), 32'h01);
        step();
        chk("pre_rst_uo",    32'(bus_if.update_out),  32'h1);
        chk("pre_rst_bu2",   32'(bus_if.BHR_update),  32'h01);
        chk("pre_rst_pred2", 32'(bus_if.BHR_predict), 32'h03);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_upd");
        bus_if.update = 1'b0;
        rst = 1'b1;
        wait_ready("rst_upd_latency");

        // Reset mid-sweep: the sweep must restart from index 0.
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk("mid_init_ready", 32'(bus_if.ready), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_init");
        rst = 1'b1;
        wait_ready("rst_init_latency");
        scan_zero("rst_init_entry");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
